// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one-entry pipeline register between EXE and WB that merges
// synchronous SRAM read data with the ALU result and publishes a forwarding bus for decode.
module mem_stage #(
  parameter int DW     = 32,
  parameter bit FWD_LD = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MEM_signal_valid,
  input  logic [DW+38:0] MEM_signal,
  input  logic [DW-1:0]  data_sram_rdata,
  input  logic           WB_allowin,
  output logic           MEM_allowin,
  output logic           WB_signal_valid,
  output logic [DW+37:0] WB_signal,
  output logic           MEM_fwd_we,
  output logic [4:0]     MEM_fwd_waddr,
  output logic [DW-1:0]  MEM_fwd_data,
  output logic           MEM_fwd_ld
);

  typedef struct packed {
    logic [31:0]   pc;
    logic          res_from_mem;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] alu_result;
  } payload_t;

  localparam logic MemReadygo = 1'b1;

  payload_t      payload_q;
  logic          mem_valid;
  logic          first_q;
  logic          held_q;
  logic [DW-1:0] hold_q;

  logic          accept;
  logic          leave;
  logic          capture;
  logic [DW-1:0] load_data;
  logic [DW-1:0] final_result;

  assign MEM_allowin = !mem_valid || (MemReadygo && WB_allowin);
  assign accept      = MEM_signal_valid && MEM_allowin;
  assign leave       = mem_valid && MemReadygo && WB_allowin;

  // SRAM data is only trustworthy in the first cycle; a stalled EXE keeps the SRAM
  // enabled, so a stalled load must latch its word before it is overwritten.
  assign capture = mem_valid && first_q && payload_q.res_from_mem && !WB_allowin;

  // NOTE: control state is reset; the datapath hold register is not, because it is
  // only ever read while held_q is set, and held_q is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      payload_q <= '0;
      first_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      if (MEM_allowin) mem_valid <= MEM_signal_valid;
      if (accept)      payload_q <= payload_t'(MEM_signal);
      first_q <= accept;
      // A departing or newly arriving instruction always discards a stale capture.
      if (accept || leave) held_q <= 1'b0;
      else if (capture)    held_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) hold_q <= data_sram_rdata;
  end

  assign load_data    = held_q ? hold_q : data_sram_rdata;
  assign final_result = payload_q.res_from_mem ? load_data : payload_q.alu_result;

  assign WB_signal_valid = mem_valid;
  assign WB_signal       = {payload_q.pc, payload_q.rf_we, payload_q.rf_waddr, final_result};

  assign MEM_fwd_we    = mem_valid && payload_q.rf_we && (payload_q.rf_waddr != 5'd0);
  assign MEM_fwd_waddr = payload_q.rf_waddr;
  assign MEM_fwd_data  = final_result;
  assign MEM_fwd_ld    = mem_valid && payload_q.res_from_mem && !FWD_LD;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random traffic, all
// compared each cycle against a slot-level reference model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_signal_valid;
  logic [70:0] MEM_signal;
  logic [31:0] data_sram_rdata;
  logic        WB_allowin;
  logic        MEM_allowin;
  logic        WB_signal_valid;
  logic [69:0] WB_signal;
  logic        MEM_fwd_we;
  logic [4:0]  MEM_fwd_waddr;
  logic [31:0] MEM_fwd_data;
  logic        MEM_fwd_ld;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage #(.DW(32), .FWD_LD(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .MEM_signal_valid (MEM_signal_valid),
    .MEM_signal       (MEM_signal),
    .data_sram_rdata  (data_sram_rdata),
    .WB_allowin       (WB_allowin),
    .MEM_allowin      (MEM_allowin),
    .WB_signal_valid  (WB_signal_valid),
    .WB_signal        (WB_signal),
    .MEM_fwd_we       (MEM_fwd_we),
    .MEM_fwd_waddr    (MEM_fwd_waddr),
    .MEM_fwd_data     (MEM_fwd_data),
    .MEM_fwd_ld       (MEM_fwd_ld)
  );

  // Reference model: the single instruction slot plus the load word that arrived
  // in the cycle right after it was accepted.
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_rfm;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_alu;
  logic        m_first;
  logic [31:0] m_ld;

  function automatic logic [70:0] mk(input logic [31:0] pc, input logic rfm, input logic we,
                                     input logic [4:0] wa, input logic [31:0] alu);
    return {pc, rfm, we, wa, alu};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and compare every output with the model.
  task automatic drive(input logic rst, input logic sv, input logic [70:0] sig,
                       input logic [31:0] rd, input logic wba);
    logic [31:0] e_load, e_final;
    reset            = rst;
    MEM_signal_valid = sv;
    MEM_signal       = sig;
    data_sram_rdata  = rd;
    WB_allowin       = wba;
    #2;
    // Once past its first cycle, a resident load must use the word seen in that cycle.
    e_load  = (m_valid && !m_first) ? m_ld : rd;
    e_final = m_rfm ? e_load : m_alu;
    chk("allowin",   70'(MEM_allowin),     70'(!m_valid || wba));
    chk("wb_valid",  70'(WB_signal_valid), 70'(m_valid));
    chk("wb_signal", WB_signal,            {m_pc, m_we, m_wa, e_final});
    chk("fwd_we",    70'(MEM_fwd_we),      70'(m_valid && m_we && (m_wa != 5'd0)));
    chk("fwd_waddr", 70'(MEM_fwd_waddr),   70'(m_wa));
    chk("fwd_data",  70'(MEM_fwd_data),    70'(e_final));
    chk("fwd_ld",    70'(MEM_fwd_ld),      70'(0));
  endtask

  // Advance the model over the coming edge using the inputs currently driven.
  task automatic tick();
    logic allow;
    if (reset) begin
      m_valid = 1'b0; m_pc = '0; m_rfm = 1'b0; m_we = 1'b0; m_wa = '0; m_alu = '0;
      m_first = 1'b0;
    end else begin
      allow = !m_valid || WB_allowin;
      if (m_first) m_ld = data_sram_rdata;
      if (allow && MEM_signal_valid)
        {m_pc, m_rfm, m_we, m_wa, m_alu} = MEM_signal;
      if (allow) m_valid = MEM_signal_valid;
      m_first = allow && MEM_signal_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rst, input logic sv, input logic [70:0] sig,
                      input logic [31:0] rd, input logic wba);
    drive(rst, sv, sig, rd, wba);
    tick();
  endtask

  logic [70:0] op_a, op_b, op_c, ld;

  initial begin
    m_valid = 1'b0; m_pc = '0; m_rfm = 1'b0; m_we = 1'b0; m_wa = '0; m_alu = '0;
    m_first = 1'b0; m_ld = '0;
    reset = 1'b1; MEM_signal_valid = 1'b0; MEM_signal = '0; data_sram_rdata = '0;
    WB_allowin = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 1'b0, '0, 32'h0, 1'b1);

    // Reset state
    drive(1'b0, 1'b0, '0, 32'h5555_aaaa, 1'b1);
    chk("rst_wb_signal", WB_signal, 70'h0);
    tick();

    // 1: ALU op
    op_a = mk(32'h1c00_0000, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
    step(1'b0, 1'b1, op_a, 32'h0, 1'b1);
    drive(1'b0, 1'b0, '0, 32'hffff_ffff, 1'b1);
    chk("t1_final", 70'(WB_signal[31:0]), 70'h1234_5678);
    chk("t1_fwd_waddr", 70'(MEM_fwd_waddr), 70'd5);
    tick();

    // 2: load without stall
    ld = mk(32'h1c00_0004, 1'b1, 1'b1, 5'd7, 32'h0000_1000);
    step(1'b0, 1'b1, ld, 32'h0, 1'b1);
    drive(1'b0, 1'b0, '0, 32'hdead_beef, 1'b1);
    chk("t2_final", 70'(MEM_fwd_data), 70'hdead_beef);
    tick();
    step(1'b0, 1'b0, '0, 32'h0, 1'b1);

    // 3: load held over a 3-cycle WB stall while the SRAM output changes
    step(1'b0, 1'b1, ld, 32'h0, 1'b1);
    step(1'b0, 1'b1, op_a, 32'hdead_beef, 1'b0);
    drive(1'b0, 1'b1, op_a, 32'h0, 1'b0);
    chk("t3_final", 70'(MEM_fwd_data), 70'hdead_beef);
    chk("t3_allowin", 70'(MEM_allowin), 70'd0);
    tick();
    step(1'b0, 1'b1, op_a, 32'h0, 1'b0);
    step(1'b0, 1'b0, '0, 32'h0, 1'b1);

    // 4: bubble keeps payload; r0 never forwards
    step(1'b0, 1'b0, '0, 32'h0, 1'b1);
    step(1'b0, 1'b1, mk(32'h1c00_0010, 1'b0, 1'b1, 5'd0, 32'h77), 32'h0, 1'b1);
    drive(1'b0, 1'b0, '0, 32'h0, 1'b1);
    chk("t4_r0_fwd_we", 70'(MEM_fwd_we), 70'd0);
    tick();

    // 5: reset in the middle of a load stall
    step(1'b0, 1'b1, ld, 32'h0, 1'b1);
    step(1'b0, 1'b0, '0, 32'hdead_beef, 1'b0);
    step(1'b1, 1'b0, '0, 32'h1111_2222, 1'b0);
    drive(1'b0, 1'b0, '0, 32'h0, 1'b0);
    chk("t5_allowin", 70'(MEM_allowin), 70'd1);
    chk("t5_wb_signal", WB_signal, 70'h0);
    tick();

    // 6: back-to-back A,B,C with a one-cycle WB stall while B is in MEM
    op_a = mk(32'h1c00_0020, 1'b0, 1'b1, 5'd1, 32'haaaa_0001);
    op_b = mk(32'h1c00_0024, 1'b0, 1'b1, 5'd2, 32'hbbbb_0002);
    op_c = mk(32'h1c00_0028, 1'b0, 1'b1, 5'd3, 32'hcccc_0003);
    step(1'b0, 1'b1, op_a, 32'h0, 1'b1);
    step(1'b0, 1'b1, op_b, 32'h0, 1'b1);
    drive(1'b0, 1'b1, op_c, 32'h0, 1'b0);
    chk("t6_b_first", 70'(WB_signal[31:0]), 70'hbbbb_0002);
    tick();
    drive(1'b0, 1'b1, op_c, 32'h0, 1'b1);
    chk("t6_b_repeat", 70'(WB_signal[31:0]), 70'hbbbb_0002);
    tick();
    drive(1'b0, 1'b0, '0, 32'h0, 1'b1);
    chk("t6_c", 70'(WB_signal[31:0]), 70'hcccc_0003);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           mk($urandom, 1'($urandom), 1'($urandom), wa, $urandom),
           $urandom,
           $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
